// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and helpers for the ADC capture front end
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  // Accumulator must hold 2^max_avg_log2 full-scale samples without overflow.
  function automatic int acc_width(input int data_w, input int max_avg_log2);
    return data_w + max_avg_log2;
  endfunction

endpackage

// File: rtl/adc_ch_acc.sv
// rtl/adc_ch_acc.sv - per-channel boxcar accumulator, shifter and overrange OR
module adc_ch_acc
  import adc_pkg::*;
#(
  parameter int DATA_W       = 14,
  parameter int MAX_AVG_LOG2 = 4
) (
  input  logic              CLK_65,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic              last,
  input  logic [2:0]        shift,
  input  logic [DATA_W-1:0] sample,
  input  logic              otr,
  output logic [DATA_W-1:0] data,
  output logic              otr_flag
);

  localparam int ACC_W = acc_width(DATA_W, MAX_AVG_LOG2);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] avg;
  logic              otr_acc;
  logic              otr_win;

  assign sum     = acc + ACC_W'(sample);
  assign avg     = DATA_W'(sum >> shift);
  assign otr_win = otr_acc | otr;

  // Running window sum; restarts after the last sample or when the run is left.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      otr_acc <= 1'b0;
    end else if (en && !last) begin
      acc     <= sum;
      otr_acc <= otr_win;
    end else if (en || clr) begin
      acc     <= '0;
      otr_acc <= 1'b0;
    end
  end

  // Output register: floor average and window overrange, held between windows.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      data     <= '0;
      otr_flag <= 1'b0;
    end else if (en && last) begin
      data     <= avg;
      otr_flag <= otr_win;
    end
  end

endmodule

// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - N-channel ADC capture with averaging, decimation and burst control
module adc_capture
  import adc_pkg::*;
#(
  parameter int DATA_W       = 14,
  parameter int N_CH         = 2,
  parameter int MAX_AVG_LOG2 = 4,
  parameter int CNT_W        = 16
) (
  input  logic                   CLK_65,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   mode,
  input  logic                   start,
  input  logic [CNT_W-1:0]       burst_len,
  input  logic [2:0]             avg_log2,
  input  logic                   clr_otr,
  output logic [N_CH-1:0]        adc_clk,
  output logic [N_CH-1:0]        adc_oeb,
  input  logic [N_CH*DATA_W-1:0] adc_data,
  input  logic [N_CH-1:0]        adc_otr,
  output logic [N_CH*DATA_W-1:0] data_out,
  output logic                   data_valid,
  output logic [N_CH-1:0]        otr_flag,
  output logic [N_CH-1:0]        otr_sticky,
  output logic [CNT_W-1:0]       sample_cnt,
  output logic                   busy,
  output logic                   done
);

  localparam logic [2:0] AVG_MAX = 3'(MAX_AVG_LOG2);
  localparam int         WIN_W   = MAX_AVG_LOG2;

  state_t                  state;
  state_t                  state_next;
  logic [N_CH*DATA_W-1:0]  data_q;
  logic [N_CH-1:0]         otr_q;
  logic                    live_q;
  logic                    mode_q;
  logic [CNT_W-1:0]        len_q;
  logic [2:0]              a_q;
  logic [2:0]              a_clamped;
  logic [WIN_W-1:0]        win_cnt;
  logic [WIN_W-1:0]        win_max;
  logic                    win_last;
  logic                    enter_run;
  logic                    stay_run;
  logic                    acc_en;
  logic                    acc_clr;
  logic                    burst_end;

  // Converters run directly off the sample clock and are always driving.
  assign adc_clk = {N_CH{CLK_65}};
  assign adc_oeb = '0;

  assign a_clamped = (avg_log2 > AVG_MAX) ? AVG_MAX : avg_log2;
  assign win_max   = WIN_W'((32'd1 << a_q) - 32'd1);
  assign win_last  = (win_cnt == win_max);

  // Burst ends once the last requested output has been presented (or at once for length 0).
  assign burst_end = (mode_q == MODE_BURST) &&
                     ((len_q == '0) ||
                      (data_valid && (sample_cnt == len_q - CNT_W'(1))));

  assign enter_run = (state == IDLE) && (state_next == RUN);
  assign stay_run  = (state == RUN) && (state_next == RUN);
  // live_q delays accumulation so the first sample used is the one registered after entry.
  assign acc_en    = stay_run && live_q;
  assign acc_clr   = !stay_run;

  // Raw sample and overrange capture, independent of state.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      otr_q  <= '0;
      live_q <= 1'b0;
    end else begin
      data_q <= adc_data;
      otr_q  <= adc_otr;
      live_q <= (state == RUN);
    end
  end

  // State register.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (((mode == MODE_CONT) && enable) || ((mode == MODE_BURST) && start)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if ((mode_q == MODE_CONT) && !enable) begin
          state_next = IDLE;
        end else if (burst_end) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Run parameters are frozen for the duration of a run.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_CONT;
      len_q  <= '0;
      a_q    <= '0;
    end else if (enter_run) begin
      mode_q <= mode;
      len_q  <= burst_len;
      a_q    <= a_clamped;
    end
  end

  // Shared window position; cleared whenever the run is not continuing.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt <= '0;
    end else if (acc_en) begin
      win_cnt <= win_last ? '0 : win_cnt + WIN_W'(1);
    end else if (acc_clr) begin
      win_cnt <= '0;
    end
  end

  // One valid per completed window; the index advances after each output.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      data_valid <= 1'b0;
      sample_cnt <= '0;
    end else begin
      data_valid <= acc_en && win_last;
      if (enter_run) begin
        sample_cnt <= '0;
      end else if (data_valid) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky overrange: a new overrange in the same cycle as a clear is kept.
  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      otr_sticky <= '0;
    end else begin
      otr_sticky <= (otr_sticky & ~{N_CH{clr_otr}}) | otr_q;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    adc_ch_acc #(
      .DATA_W       (DATA_W),
      .MAX_AVG_LOG2 (MAX_AVG_LOG2)
    ) u_acc (
      .CLK_65   (CLK_65),
      .reset_n  (reset_n),
      .clr      (acc_clr),
      .en       (acc_en),
      .last     (win_last),
      .shift    (a_q),
      .sample   (data_q[c*DATA_W +: DATA_W]),
      .otr      (otr_q[c]),
      .data     (data_out[c*DATA_W +: DATA_W]),
      .otr_flag (otr_flag[c])
    );
  end

endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - scoreboard bench for adc_capture
module tb_adc_capture;

  localparam int DATA_W       = 14;
  localparam int N_CH         = 2;
  localparam int MAX_AVG_LOG2 = 4;
  localparam int CNT_W        = 16;

  logic                   CLK_65 = 1'b0;
  logic                   reset_n;
  logic                   enable;
  logic                   mode;
  logic                   start;
  logic [CNT_W-1:0]       burst_len;
  logic [2:0]             avg_log2;
  logic                   clr_otr;
  logic [N_CH-1:0]        adc_clk;
  logic [N_CH-1:0]        adc_oeb;
  logic [N_CH*DATA_W-1:0] adc_data;
  logic [N_CH-1:0]        adc_otr;
  logic [N_CH*DATA_W-1:0] data_out;
  logic                   data_valid;
  logic [N_CH-1:0]        otr_flag;
  logic [N_CH-1:0]        otr_sticky;
  logic [CNT_W-1:0]       sample_cnt;
  logic                   busy;
  logic                   done;

  adc_capture #(
    .DATA_W(DATA_W), .N_CH(N_CH), .MAX_AVG_LOG2(MAX_AVG_LOG2), .CNT_W(CNT_W)
  ) dut (
    .CLK_65(CLK_65), .reset_n(reset_n), .enable(enable), .mode(mode), .start(start),
    .burst_len(burst_len), .avg_log2(avg_log2), .clr_otr(clr_otr),
    .adc_clk(adc_clk), .adc_oeb(adc_oeb), .adc_data(adc_data), .adc_otr(adc_otr),
    .data_out(data_out), .data_valid(data_valid), .otr_flag(otr_flag),
    .otr_sticky(otr_sticky), .sample_cnt(sample_cnt), .busy(busy), .done(done)
  );

  always #5 CLK_65 = ~CLK_65;

  typedef struct {
    int d0;
    int d1;
    int otr;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   done_q = 0;
  int   total  = 0;
  int   bad    = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK_65);
    #1;
  endtask

  task automatic set_pins(input int d0, input int d1, input logic [1:0] o);
    adc_data = {DATA_W'(d1), DATA_W'(d0)};
    adc_otr  = o;
  endtask

  task automatic push_exp(input int d0, input int d1, input int o, input int c);
    exp_t e;
    e.d0 = d0; e.d1 = d1; e.otr = o; e.cnt = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every valid output is matched against the oldest expected entry.
  always @(negedge CLK_65) begin
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got data %0d/%0d want no output",
                 data_out[DATA_W-1:0], data_out[2*DATA_W-1:DATA_W]);
      end else begin
        m_e = exp_q.pop_front();
        chk("data0", int'(data_out[DATA_W-1:0]), m_e.d0);
        chk("data1", int'(data_out[2*DATA_W-1:DATA_W]), m_e.d1);
        chk("otr_flag", int'(otr_flag), m_e.otr);
        chk("sample_cnt", int'(sample_cnt), m_e.cnt);
      end
    end
    if (done) begin
      chk("done_expected", int'(done_q > 0), 1);
      if (done_q > 0) done_q--;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; mode = 1'b0; start = 1'b0;
    burst_len = '0; avg_log2 = '0; clr_otr = 1'b0; adc_data = '0; adc_otr = '0;

    // Reset held with toggling inputs.
    for (int i = 0; i < 4; i++) begin
      adc_data = 28'($urandom);
      adc_otr  = 2'($urandom);
      enable   = 1'($urandom);
      start    = 1'($urandom);
      mode     = 1'($urandom);
      clr_otr  = 1'($urandom);
      tick();
    end
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_otr_flag", int'(otr_flag), 0);
    chk("rst_sticky", int'(otr_sticky), 0);
    chk("rst_cnt", int'(sample_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_oeb", int'(adc_oeb), 0);
    enable = 0; start = 0; mode = 0; clr_otr = 0; set_pins(0, 0, 2'b00);
    tick();
    reset_n = 1'b1;
    tick();

    // Continuous passthrough, a=0.
    avg_log2 = 3'd0; enable = 1'b1;
    tick();
    chk("cont_busy", int'(busy), 1);
    for (int i = 0; i < 10; i++) begin
      set_pins(i, 9 - i, 2'b00);
      push_exp(i, 9 - i, 0, i);
      tick();
    end
    set_pins(500, 500, 2'b00);
    tick();
    enable = 1'b0;
    tick(); tick();
    chk("cont_stop_busy", int'(busy), 0);

    // Averaging, a=2: two windows including full scale.
    avg_log2 = 3'd2; enable = 1'b1;
    tick();
    push_exp(101, 202, 0, 0);
    push_exp(5, 16383, 0, 1);
    set_pins(100, 200, 2'b00); tick();
    set_pins(101, 201, 2'b00); tick();
    set_pins(102, 202, 2'b00); tick();
    set_pins(103, 207, 2'b00); tick();
    set_pins(4, 16383, 2'b00); tick();
    set_pins(5, 16383, 2'b00); tick();
    set_pins(6, 16383, 2'b00); tick();
    set_pins(7, 16383, 2'b00); tick();
    set_pins(0, 0, 2'b00); tick();
    enable = 1'b0;
    tick(); tick();

    // Overrange inside one a=2 window.
    enable = 1'b1;
    tick();
    push_exp(10, 0, 0, 0);
    push_exp(21, 0, 2, 1);
    push_exp(0, 0, 0, 2);
    for (int i = 0; i < 4; i++) begin set_pins(10, 0, 2'b00); tick(); end
    for (int i = 0; i < 4; i++) begin set_pins(20 + i, 0, (i == 1) ? 2'b10 : 2'b00); tick(); end
    for (int i = 0; i < 4; i++) begin set_pins(0, 0, 2'b00); tick(); end
    tick();
    enable = 1'b0;
    tick(); tick();
    chk("sticky_set", int'(otr_sticky), 2);
    clr_otr = 1'b1; tick(); clr_otr = 1'b0; tick();
    chk("sticky_clr", int'(otr_sticky), 0);
    set_pins(0, 0, 2'b10); tick();
    set_pins(0, 0, 2'b00); clr_otr = 1'b1; tick();
    clr_otr = 1'b0;
    chk("sticky_set_wins", int'(otr_sticky), 2);
    clr_otr = 1'b1; tick(); clr_otr = 1'b0; tick();
    chk("sticky_clr2", int'(otr_sticky), 0);

    // Burst of 3, a=1, with a stray start and burst_len change mid-run.
    mode = 1'b1; burst_len = 16'd3; avg_log2 = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("burst_busy", int'(busy), 1);
    push_exp(2, 0, 0, 0);
    push_exp(10, 100, 0, 1);
    push_exp(7, 5, 0, 2);
    done_q++;
    set_pins(1, 0, 2'b00); tick();
    set_pins(3, 1, 2'b00); tick();
    set_pins(10, 100, 2'b00); start = 1'b1; burst_len = 16'd10; tick(); start = 1'b0;
    set_pins(11, 100, 2'b00); tick();
    set_pins(7, 5, 2'b00); tick();
    set_pins(8, 6, 2'b00); tick();
    set_pins(999, 999, 2'b00); tick();
    chk("burst_last_busy", int'(busy), 1);
    chk("burst_last_done", int'(done), 0);
    tick();
    chk("burst_done", int'(done), 1);
    chk("burst_done_busy", int'(busy), 0);
    tick();
    chk("burst_done_clr", int'(done), 0);
    tick(); tick(); tick();
    chk("burst_idle", int'(busy), 0);

    // Burst of length 0.
    burst_len = 16'd0; start = 1'b1; done_q++;
    tick();
    start = 1'b0;
    chk("len0_busy", int'(busy), 1);
    tick();
    chk("len0_done", int'(done), 1);
    tick();
    chk("len0_done_clr", int'(done), 0);
    tick(); tick();

    // Abort a partial window, then restart.
    mode = 1'b0; avg_log2 = 3'd2; enable = 1'b1;
    tick();
    set_pins(1000, 1000, 2'b00);
    tick(); tick(); tick();
    enable = 1'b0;
    tick(); tick();
    chk("abort_busy", int'(busy), 0);
    enable = 1'b1;
    tick();
    push_exp(8, 2, 0, 0);
    set_pins(8, 0, 2'b00); tick();
    set_pins(8, 4, 2'b00); tick();
    set_pins(8, 0, 2'b00); tick();
    set_pins(8, 4, 2'b00); tick();
    set_pins(0, 0, 2'b00); tick();
    enable = 1'b0;
    tick(); tick();

    // Asynchronous reset in the middle of a burst.
    set_pins(0, 0, 2'b01); tick();
    set_pins(0, 0, 2'b00); tick();
    chk("pre_rst_sticky", int'(otr_sticky), 1);
    mode = 1'b1; burst_len = 16'd5; avg_log2 = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    push_exp(11, 21, 0, 0);
    push_exp(12, 22, 0, 1);
    set_pins(11, 21, 2'b00); tick();
    set_pins(12, 22, 2'b00); tick();
    set_pins(13, 23, 2'b00); tick();
    #6;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_data", int'(data_out), 0);
    chk("mid_rst_valid", int'(data_valid), 0);
    chk("mid_rst_cnt", int'(sample_cnt), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_sticky", int'(otr_sticky), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_busy", int'(busy), 0);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_q_drained", done_q, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
